ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
- Shares the single-port 4096x16 synchronous RAM (`ram`) between two requesters.
  - Port 0: CPU fetch/data.
  - Port 1: loader/DMA.
- Round-robin arbitration with a registered request/acknowledge handshake.
- Drives the RAM's `load`/`addr`/`d` pins and returns `q` with a per-port read-valid strobe.
- Sits between tinycpu core, loader and `ram`; the RAM's one-cycle registered read latency is accounted for here.

Parameters:
- AWIDTH, 12, address width (4096 words)
- DWIDTH, 16, data width

Ports:
- clk      in   1       system clock, all logic on rising edge
- reset    in   1       synchronous, active-high reset
- req0     in   1       port 0 request; hold with we0/addr0/wdata0 stable until ack0
- we0      in   1       port 0: 1=write, 0=read
- addr0    in   AWIDTH  port 0 address
- wdata0   in   DWIDTH  port 0 write data
- ack0     out  1       one-cycle pulse: port 0 request accepted
- rvalid0  out  1       one-cycle pulse: rdata holds port 0 read result
- req1/we1/addr1/wdata1/ack1/rvalid1   same as port 0, for port 1
- rdata    out  DWIDTH  read data, wired directly from ram_q
- ram_load out  1       to ram.load
- ram_addr out  AWIDTH  to ram.addr
- ram_d    out  DWIDTH  to ram.d
- ram_q    in   DWIDTH  from ram.q

Behaviour:
- Synchronous active-high reset; one clock domain, clk.
- Reset values:
  - ack0, ack1, rvalid0, rvalid1 = 0
  - ram_load = 0, ram_addr = 0, ram_d = 0
  - last_grant = 1, so port 0 wins the first contention.
- Eligibility: port n is eligible at an edge if reqn=1 and ackn=0 in that cycle. A port is never re-sampled in its own ack cycle.
- Arbitration at every rising edge (E1):
  - Neither eligible: ram_load<=0, ram_addr/ram_d hold, no ack.
  - One eligible: grant that port.
  - Both eligible: grant port != last_grant.
- On grant at E1:
  - ram_addr<=addrN; ram_d<=wdataN; ram_load<=weN.
  - ackN<=1 for exactly one cycle; last_grant<=N.
  - rd_pend<=!weN; rd_owner<=N.
- At E2 the RAM executes the command. For a read at E2: rvalidN<=1 for one cycle; ram_q/rdata is valid in that same cycle (after E2).
- Latency:
  - req sampled at E1 → ack during cycle E1..E2.
  - Write committed at E2.
  - Read data and rvalid during cycle E2..E3.
- Throughput:
  - Alternating ports can get a grant at every edge (1 op/cycle).
  - A single port alone gets at most 1 op per 2 cycles, because of the ack-cycle exclusion.
- Ordering: one command per RAM cycle, so no read/write collision. A read issued right after a write to the same address returns the new data.
- ram_load is high for exactly one cycle per granted write, never two consecutive cycles for one ack.
- rdata is not gated; consumers qualify it with rvalidN only.
- Reset mid-operation:
  - If reset is sampled at E2 for a write granted at E1, the RAM still writes (ram_load was 1 before the edge).
  - All pending rvalid is dropped; rvalid stays 0 in the cycle after reset.
  - Requesters must reissue anything un-acked.
- A request dropped before ack is simply not served; no state is kept for it.
- Writes never produce rvalid.

Test Plan:
- Reset, then req0 write addr0=12'h001 wdata0=16'h1234 → ack0 one cycle later; ram_load=1, ram_addr=12'h001, ram_d=16'h1234 for one cycle; no rvalid0.
- Then req0 read addr0=12'h001 → ack0, next cycle rvalid0=1 and rdata=16'h1234; rvalid1 stays 0.
- Both ports held reading 12'h010/12'h020 for 8 cycles (memory preloaded 16'h00AA/16'h00BB):
  - first grant is port 0, then strictly alternating;
  - rvalid0 with 16'h00AA, rvalid1 with 16'h00BB on alternate cycles;
  - 4 acks each.
- Port 1 alone holding req1 (read) continuously → ack1 every second cycle; rvalid1 one cycle after each ack1.
- Port 0 writes 16'h5A5A to 12'hFFF; port 1 reads 12'hFFF granted on the next edge → rvalid1 with rdata=16'h5A5A (upper-address boundary).
- reset asserted on the edge after a port 0 write ack (addr 12'h100, data 16'hBEEF), with a port 1 read pending:
  - mem[12'h100]=16'hBEEF afterwards;
  - no rvalid1;
  - all outputs 0 the next cycle;
  - first post-reset contention granted to port 0.

Source files
------------

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_arbiter
// Purpose  : Round-robin sharing of a single-port synchronous RAM between two
//            requesters with ack pulses and per-port read-valid strobes.
// Revision : 1.0  initial release
// ============================================================================
module ram_arbiter #(
  parameter int AWIDTH = 12,
  parameter int DWIDTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [AWIDTH-1:0] addr0,
  input  logic [DWIDTH-1:0] wdata0,
  output logic              ack0,
  output logic              rvalid0,
  input  logic              req1,
  input  logic              we1,
  input  logic [AWIDTH-1:0] addr1,
  input  logic [DWIDTH-1:0] wdata1,
  output logic              ack1,
  output logic              rvalid1,
  output logic [DWIDTH-1:0] rdata,
  output logic              ram_load,
  output logic [AWIDTH-1:0] ram_addr,
  output logic [DWIDTH-1:0] ram_d,
  input  logic [DWIDTH-1:0] ram_q
);

  localparam logic c_port0 = 1'b0;
  localparam logic c_port1 = 1'b1;

  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic              rvalid0_q, rvalid0_d;
  logic              rvalid1_q, rvalid1_d;
  logic              load_q, load_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [DWIDTH-1:0] data_q, data_d;
  logic              last_grant_q, last_grant_d;
  logic              rd_pend_q, rd_pend_d;
  logic              rd_owner_q, rd_owner_d;

  logic              w_elig0;
  logic              w_elig1;
  logic              w_grant;
  logic              w_gport;
  logic              w_sel_we;
  logic [AWIDTH-1:0] w_sel_addr;
  logic [DWIDTH-1:0] w_sel_data;

  // A port is ineligible during its own ack cycle, so a held request is
  // never served twice for one handshake.
  assign w_elig0 = req0 & ~ack0_q;
  assign w_elig1 = req1 & ~ack1_q;
  assign w_grant = w_elig0 | w_elig1;
  assign w_gport = (w_elig0 & w_elig1) ? ~last_grant_q : w_elig1;

  assign w_sel_we   = (w_gport == c_port1) ? we1    : we0;
  assign w_sel_addr = (w_gport == c_port1) ? addr1  : addr0;
  assign w_sel_data = (w_gport == c_port1) ? wdata1 : wdata0;

  always_comb begin
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    load_d       = 1'b0;
    addr_d       = addr_q;
    data_d       = data_q;
    last_grant_d = last_grant_q;
    rd_pend_d    = 1'b0;
    rd_owner_d   = rd_owner_q;
    // The RAM executes the command one edge after the grant, so a read
    // granted last cycle has its data on ram_q after this edge.
    rvalid0_d    = rd_pend_q & (rd_owner_q == c_port0);
    rvalid1_d    = rd_pend_q & (rd_owner_q == c_port1);
    if (w_grant) begin
      addr_d       = w_sel_addr;
      data_d       = w_sel_data;
      load_d       = w_sel_we;
      last_grant_d = w_gport;
      rd_pend_d    = ~w_sel_we;
      rd_owner_d   = w_gport;
      ack0_d       = (w_gport == c_port0);
      ack1_d       = (w_gport == c_port1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      rvalid0_q    <= 1'b0;
      rvalid1_q    <= 1'b0;
      load_q       <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      last_grant_q <= c_port1;
      rd_pend_q    <= 1'b0;
      rd_owner_q   <= c_port0;
    end else begin
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      rvalid0_q    <= rvalid0_d;
      rvalid1_q    <= rvalid1_d;
      load_q       <= load_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      last_grant_q <= last_grant_d;
      rd_pend_q    <= rd_pend_d;
      rd_owner_q   <= rd_owner_d;
    end
  end

  assign ack0     = ack0_q;
  assign ack1     = ack1_q;
  assign rvalid0  = rvalid0_q;
  assign rvalid1  = rvalid1_q;
  assign ram_load = load_q;
  assign ram_addr = addr_q;
  assign ram_d    = data_q;
  assign rdata    = ram_q;

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_arbiter
// Purpose  : Scoreboard bench for ram_arbiter with a behavioural RAM and a
//            cycle-level reference model of the arbitration rules.
// Revision : 1.0  initial release
// ============================================================================
module tb_ram_arbiter;

  localparam int AWIDTH = 12;
  localparam int DWIDTH = 16;

  logic              clk;
  logic              reset;
  logic              req0, we0, req1, we1;
  logic [AWIDTH-1:0] addr0, addr1;
  logic [DWIDTH-1:0] wdata0, wdata1;
  logic              ack0, ack1, rvalid0, rvalid1;
  logic [DWIDTH-1:0] rdata;
  logic              ram_load;
  logic [AWIDTH-1:0] ram_addr;
  logic [DWIDTH-1:0] ram_d;
  logic [DWIDTH-1:0] ram_q;

  int n_checks = 0;
  int n_errors = 0;

  ram_arbiter #(.AWIDTH(AWIDTH), .DWIDTH(DWIDTH)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .ack0(ack0), .rvalid0(rvalid0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .ack1(ack1), .rvalid1(rvalid1),
    .rdata(rdata), .ram_load(ram_load), .ram_addr(ram_addr),
    .ram_d(ram_d), .ram_q(ram_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port RAM with one-cycle registered read.
  logic [DWIDTH-1:0] mem [4096];
  always @(posedge clk) begin
    if (ram_load) mem[ram_addr] <= ram_d;
    ram_q <= mem[ram_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  logic [DWIDTH-1:0] mref [4096];
  logic [DWIDTH-1:0] sb0 [$];
  logic [DWIDTH-1:0] sb1 [$];
  bit                mv = 0;
  bit                x_ack0, x_ack1, x_rv0, x_rv1, x_load;
  logic [AWIDTH-1:0] x_addr;
  logic [DWIDTH-1:0] x_d;
  int                last_port;
  int                rd_port;

  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem[i]  = 16'(i * 7) ^ 16'h3C5A;
      mref[i] = 16'(i * 7) ^ 16'h3C5A;
    end
  end

  always @(negedge clk) begin
    bit e0, e1;
    int g;
    if (mv) begin
      chk("ctrl", {27'd0, ack0, ack1, rvalid0, rvalid1, ram_load},
                  {27'd0, x_ack0, x_ack1, x_rv0, x_rv1, x_load});
      chk("ram_addr", {20'd0, ram_addr}, {20'd0, x_addr});
      chk("ram_d", {16'd0, ram_d}, {16'd0, x_d});
      if (rvalid0) begin
        if (sb0.size() == 0) chk("rvalid0_unexpected", 32'd1, 32'd0);
        else chk("rdata_p0", {16'd0, rdata}, {16'd0, sb0.pop_front()});
      end
      if (rvalid1) begin
        if (sb1.size() == 0) chk("rvalid1_unexpected", 32'd1, 32'd0);
        else chk("rdata_p1", {16'd0, rdata}, {16'd0, sb1.pop_front()});
      end
    end
    if (reset) begin
      // A read granted just before reset never gets its strobe.
      if (rd_port == 0 && sb0.size() > 0) void'(sb0.pop_back());
      if (rd_port == 1 && sb1.size() > 0) void'(sb1.pop_back());
      {x_ack0, x_ack1, x_rv0, x_rv1, x_load} = '0;
      x_addr = '0;
      x_d = '0;
      last_port = 1;
      rd_port = -1;
      mv = 1;
    end else if (mv) begin
      e0 = req0 && !x_ack0;
      e1 = req1 && !x_ack1;
      g = -1;
      if (e0 && e1) g = (last_port == 0) ? 1 : 0;
      else if (e0)  g = 0;
      else if (e1)  g = 1;
      x_rv0 = (rd_port == 0);
      x_rv1 = (rd_port == 1);
      x_ack0 = (g == 0);
      x_ack1 = (g == 1);
      x_load = 0;
      rd_port = -1;
      if (g >= 0) begin
        last_port = g;
        x_addr = (g == 0) ? addr0 : addr1;
        x_d    = (g == 0) ? wdata0 : wdata1;
        x_load = (g == 0) ? we0 : we1;
        if (x_load) mref[x_addr] = x_d;
        else begin
          if (g == 0) sb0.push_back(mref[x_addr]);
          else        sb1.push_back(mref[x_addr]);
          rd_port = g;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input int p, input bit r, input bit w,
                       input logic [AWIDTH-1:0] a, input logic [DWIDTH-1:0] d);
    if (p == 0) begin req0 = r; we0 = w; addr0 = a; wdata0 = d; end
    else        begin req1 = r; we1 = w; addr1 = a; wdata1 = d; end
  endtask

  // Called 2 time units after a rising edge; returns likewise, after the ack cycle.
  task automatic do_op(input int p, input bit w,
                       input logic [AWIDTH-1:0] a, input logic [DWIDTH-1:0] d);
    int n = 0;
    drive(p, 1'b1, w, a, d);
    forever begin
      @(posedge clk); #2;
      n++;
      if ((p == 0) ? ack0 : ack1) break;
      if (n > 50) begin
        chk("ack_timeout", 32'd0, 32'd1);
        break;
      end
    end
    drive(p, 1'b0, 1'b0, a, d);
  endtask

  task automatic idle(input int k);
    repeat (k) begin @(posedge clk); #2; end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, '0, '0);
    drive(1, 0, 0, '0, '0);
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    idle(1);

    // basic write then read-back on port 0
    do_op(0, 1'b1, 12'h001, 16'h1234);
    do_op(0, 1'b0, 12'h001, 16'h0000);
    idle(2);

    // preload, then both ports contend for 8 cycles
    do_op(0, 1'b1, 12'h010, 16'h00AA);
    do_op(1, 1'b1, 12'h020, 16'h00BB);
    idle(2);
    fork
      for (int i = 0; i < 4; i++) do_op(0, 1'b0, 12'h010, 16'h0);
      for (int i = 0; i < 4; i++) do_op(1, 1'b0, 12'h020, 16'h0);
    join
    idle(2);

    // port 1 alone, request held back-to-back
    for (int i = 0; i < 4; i++) do_op(1, 1'b0, 12'h020, 16'h0);
    idle(2);

    // upper-address write immediately followed by read from the other port
    fork
      do_op(0, 1'b1, 12'hFFF, 16'h5A5A);
      begin idle(1); do_op(1, 1'b0, 12'hFFF, 16'h0); end
    join
    idle(2);

    // reset on the edge after a write ack, with a port 1 read waiting
    drive(0, 1'b1, 1'b1, 12'h100, 16'hBEEF);
    drive(1, 1'b1, 1'b0, 12'h010, 16'h0);
    @(posedge clk); #2;
    chk("rst_wr_ack", {30'd0, ack0, ack1}, 32'd2);
    reset = 1'b1;
    drive(0, 1'b0, 1'b0, 12'h0, 16'h0);
    @(posedge clk); #2;
    reset = 1'b0;
    drive(1, 1'b0, 1'b0, 12'h0, 16'h0);
    chk("rst_mem_written", {16'd0, mem[12'h100]}, 32'h0000BEEF);
    chk("rst_outputs_zero", {27'd0, ack0, ack1, rvalid0, rvalid1, ram_load}, 32'd0);
    chk("rst_addr_d_zero", {4'd0, ram_addr, ram_d}, 32'd0);
    fork
      do_op(0, 1'b0, 12'h100, 16'h0);
      do_op(1, 1'b0, 12'h020, 16'h0);
      begin @(posedge clk); #1; chk("post_rst_arb", {30'd0, ack0, ack1}, 32'd2); end
    join
    idle(2);

    // randomized traffic on a small address window to force collisions
    fork
      for (int i = 0; i < 30; i++) begin
        do_op(0, 1'($urandom_range(0, 1)), 12'h200 + 12'($urandom_range(0, 7)), 16'($urandom));
        idle($urandom_range(0, 2));
      end
      for (int i = 0; i < 30; i++) begin
        do_op(1, 1'($urandom_range(0, 1)), 12'h200 + 12'($urandom_range(0, 7)), 16'($urandom));
        idle($urandom_range(0, 2));
      end
    join
    idle(4);

    chk("sb0_drained", sb0.size(), 32'd0);
    chk("sb1_drained", sb1.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
